mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have port: Clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: Run  input  1  level start request.
REQ-004 SHALL have port: ClearA_LoadB  input  1  level load request; B:=Din, A:=0, X:=0.
REQ-005 SHALL have port: Din  input  8  switch operand S (multiplicand), also B load value.
REQ-006 SHALL have port: Sum  input  9  result from external 9-bit add/sub datapath.
REQ-007 SHALL have port: OpA  output  8  datapath x operand, equals Aval.
REQ-008 SHALL have port: OpB  output  8  datapath y operand, equals Din.
REQ-009 SHALL have port: Fn  output  1  datapath function; 0 add, 1 subtract.
REQ-010 SHALL have port: Aval  output  8  register A (product high byte).
REQ-011 SHALL have port: Bval  output  8  register B (multiplier, product low byte).
REQ-012 SHALL have port: X  output  1  sign-extension flip-flop.
REQ-013 SHALL have port: Done  output  1  high while in HALT.
REQ-014 SHALL have a single clock domain; Reset is synchronous and active-high.

Function
REQ-015 SHALL implement FSM states IDLE, CLR, ADD, SHIFT and HALT, plus a 3-bit step counter.
REQ-016 IDLE: ClearA_LoadB=1 SHALL load B:=Din, A:=0, X:=0 and stay in IDLE; otherwise Run=1 SHALL go to CLR; if both are high, the load wins and Run is ignored that cycle.
REQ-017 CLR: SHALL set A:=0, X:=0 and count:=0, leave B unchanged, then go to ADD.
REQ-018 ADD: if B[0]=1, SHALL set X:=Sum[8] and A:=Sum[7:0]; if B[0]=0, A and X hold; always go to SHIFT.
REQ-019 Fn SHALL be 1 only in ADD with count=7, and 0 at all other times.
REQ-020 SHIFT: SHALL shift {X,A,B} right by one arithmetically (X unchanged, A[7]:=X, B[7]:=A[0]).
REQ-021 SHIFT: count=7 SHALL go to HALT; otherwise count increments and the FSM goes to ADD.
REQ-022 HALT: Done=1 and registers hold; Run=0 SHALL go to IDLE; Run held high SHALL NOT restart.
REQ-023 Latency: Run sampled at edge k SHALL give Done=1 after edge k+17 (CLR + 8 ADD + 8 SHIFT).
REQ-024 ClearA_LoadB and Din changes outside IDLE SHALL be ignored by the FSM; Din SHALL be held stable by the user during operation.
REQ-025 Result SHALL be the signed 16-bit product {Aval,Bval} of Din times the original B, valid for all operand pairs including -128*-128.
REQ-026 Back-to-back runs SHALL multiply the current B (the previous low byte) by Din, with A cleared in CLR.

Reset
REQ-027 Reset=1 at a rising edge SHALL force IDLE, count=0, A=0, B=0, X=0, Done=0 and Fn=0, from any state including mid-operation.
REQ-028 Reset SHALL take priority over Run and ClearA_LoadB.

Configuration
REQ-029 Macro MULT_SKIP_ZERO_EN SHALL select the zero-skip feature.
REQ-030 With MULT_SKIP_ZERO_EN defined, the ADD state SHALL be skipped when B[0]=0 (CLR or SHIFT goes directly to SHIFT), so latency = 9 + popcount(original B) cycles; the result is unchanged.
REQ-031 Without MULT_SKIP_ZERO_EN defined, every step SHALL visit ADD and latency SHALL be fixed at 17 cycles per REQ-023.

Verification
REQ-032 Load B=0xFD (-3) with Din=0x07, then Run pulse -> Done after 17 cycles, Aval=0xFF, Bval=0xEB, X=1.
REQ-033 B=0x80, Din=0x80 -> Aval=0x40, Bval=0x00, X=0; Fn=1 only in the cycle of the final ADD.
REQ-034 Run held high through HALT for 20 cycles -> no restart, Done stays 1; Run=0 -> IDLE next cycle.
REQ-035 Reset asserted in the 5th SHIFT -> next cycle IDLE with all outputs 0; ClearA_LoadB pulsed mid-operation -> no effect on B.
REQ-036 Run and ClearA_LoadB high together in IDLE with Din=0x05 -> B=0x05, still IDLE; second run with Din=0x02 on B=0x05 -> 0x000A, then a run with Din=0x03 -> Bval=0x1E.
REQ-037 With MULT_SKIP_ZERO_EN defined, B=0x01 and Din=0x7F -> Done after 10 cycles, product 0x007F.

Source files
------------

// File: rtl/mult_sequencer.sv
// Purpose: shift-add signed 8x8 multiplier sequencer driving an external 9-bit add/sub datapath.
// Latency: 17 cycles from Run to Done (9 + popcount(B) with MULT_SKIP_ZERO_EN defined).
// Backpressure: none; Run is a level request, HALT waits for Run to drop before re-arming.
module mult_sequencer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic [7:0] Din,
    input  logic [8:0] Sum,
    output logic [7:0] OpA,
    output logic [7:0] OpB,
    output logic       Fn,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       X,
    output logic       Done
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        HALT
    } state_t;

    state_t     state;
    logic [2:0] count;

    // Whether the next multiplier bit needs an ADD visit. Without zero-skip every
    // step adds (a zero bit just holds A/X). With zero-skip the decision looks at
    // the bit that will sit in B[0] once the current state completes: B[0] when
    // leaving CLR, B[1] when leaving SHIFT (the shift moves it down).
    logic clr_next_add;
    logic shift_next_add;

`ifdef MULT_SKIP_ZERO_EN
    assign clr_next_add   = Bval[0];
    assign shift_next_add = Bval[1];
`else
    assign clr_next_add   = 1'b1;
    assign shift_next_add = 1'b1;
`endif

    // The datapath always sees A and the switch operand; Fn picks add or subtract.
    assign OpA = Aval;
    assign OpB = Din;

    // Control FSM, step counter and A/B/X registers; Fn and Done are registered
    // and updated on entry to the state they belong to.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            count <= 3'd0;
            Aval  <= 8'h00;
            Bval  <= 8'h00;
            X     <= 1'b0;
            Done  <= 1'b0;
            Fn    <= 1'b0;
        end else begin
            Fn <= 1'b0;
            case (state)
                IDLE: begin
                    // Load has priority over start when both are requested.
                    if (ClearA_LoadB) begin
                        Bval <= Din;
                        Aval <= 8'h00;
                        X    <= 1'b0;
                    end else if (Run) begin
                        state <= CLR;
                    end
                end

                CLR: begin
                    Aval  <= 8'h00;
                    X     <= 1'b0;
                    count <= 3'd0;
                    state <= clr_next_add ? ADD : SHIFT;
                end

                ADD: begin
                    // Sum is 9 bits so the top bit is a true sign, even for -128 - (-128).
                    if (Bval[0]) begin
                        X    <= Sum[8];
                        Aval <= Sum[7:0];
                    end
                    state <= SHIFT;
                end

                SHIFT: begin
                    // Arithmetic right shift of {X,A,B}; X keeps the sign.
                    Aval <= {X, Aval[7:1]};
                    Bval <= {Aval[0], Bval[7:1]};
                    if (count == 3'd7) begin
                        state <= HALT;
                        Done  <= 1'b1;
                    end else begin
                        count <= count + 3'd1;
                        if (shift_next_add) begin
                            state <= ADD;
                            // The multiplier's sign bit carries negative weight, so
                            // the last partial product is subtracted.
                            Fn    <= (count == 3'd6);
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end

                HALT: begin
                    // Held Run must not restart; wait for it to drop.
                    if (!Run) begin
                        state <= IDLE;
                        Done  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Purpose: directed self-checking bench for mult_sequencer with a model of the external adder.
// Latency: checks Run-to-Done cycle counts and Fn timing per operand pair.
// Backpressure: n/a; all waits are bounded by a cycle budget.
module tb_mult_sequencer;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Din;
    logic [8:0] Sum;
    logic [7:0] OpA;
    logic [7:0] OpB;
    logic       Fn;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       Done;

    int checks   = 0;
    int failures = 0;

    mult_sequencer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .Din          (Din),
        .Sum          (Sum),
        .OpA          (OpA),
        .OpB          (OpB),
        .Fn           (Fn),
        .Aval         (Aval),
        .Bval         (Bval),
        .X            (X),
        .Done         (Done)
    );

    // External 9-bit add/subtract unit on sign-extended operands.
    assign Sum = Fn ? ({OpA[7], OpA} - {OpB[7], OpB})
                    : ({OpA[7], OpA} + {OpB[7], OpB});

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] b);
        int l;
        l = 9 + $countones(b);
`ifndef MULT_SKIP_ZERO_EN
        l = 17;
`endif
        return l;
    endfunction

    task automatic load_b(input logic [7:0] val);
        Din          = val;
        ClearA_LoadB = 1'b1;
        tick();
        ClearA_LoadB = 1'b0;
    endtask

    // Start a run, count edges after the Run edge until Done, and check Fn timing.
    task automatic do_run(input string tag, input logic [7:0] din, input logic [7:0] b0,
                          input logic hold, input int pulse_at);
        int n;
        int fn_cnt;
        int fn_at;
        int lat;
        int exp_fn_cnt;
        Din = din;
        Run = 1'b1;
        tick();
        if (!hold) Run = 1'b0;
        n      = 0;
        fn_cnt = 0;
        fn_at  = -1;
        while (!Done && n < 40) begin
            tick();
            n++;
            ClearA_LoadB = (n == pulse_at);
            if (Fn) begin
                fn_cnt++;
                fn_at = n;
            end
        end
        ClearA_LoadB = 1'b0;
        lat = exp_lat(b0);
`ifdef MULT_SKIP_ZERO_EN
        exp_fn_cnt = b0[7] ? 1 : 0;
`else
        exp_fn_cnt = 1;
`endif
        check({tag, " latency"}, n, lat);
        check({tag, " fn_count"}, fn_cnt, exp_fn_cnt);
        check({tag, " fn_cycle"}, fn_at, (exp_fn_cnt != 0) ? lat - 2 : -1);
    endtask

    initial begin
        int done_low;
        int b_changed;
        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        Din          = 8'h00;
        tick();
        tick();
        Reset = 1'b0;

        check("reset Aval", Aval, 8'h00);
        check("reset Bval", Bval, 8'h00);
        check("reset X",    X,    1'b0);
        check("reset Done", Done, 1'b0);
        check("reset Fn",   Fn,   1'b0);

        // -3 * 7 = -21
        load_b(8'hFD);
        check("load Bval", Bval, 8'hFD);
        do_run("m3x7", 8'h07, 8'hFD, 1'b0, -1);
        check("m3x7 Aval", Aval, 8'hFF);
        check("m3x7 Bval", Bval, 8'hEB);
        check("m3x7 X",    X,    1'b1);
        check("m3x7 OpB",  OpB,  8'h07);
        tick();
        check("m3x7 idle Done", Done, 1'b0);

        // -128 * -128 = 16384
        load_b(8'h80);
        do_run("m128", 8'h80, 8'h80, 1'b0, -1);
        check("m128 Aval", Aval, 8'h40);
        check("m128 Bval", Bval, 8'h00);
        check("m128 X",    X,    1'b0);
        tick();

        // Run held through HALT: no restart.
        load_b(8'h03);
        do_run("hold", 8'h02, 8'h03, 1'b1, -1);
        check("hold Aval", Aval, 8'h00);
        check("hold Bval", Bval, 8'h06);
        done_low  = 0;
        b_changed = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!Done) done_low++;
            if (Bval !== 8'h06) b_changed++;
        end
        check("hold Done low cycles", done_low, 0);
        check("hold Bval changes", b_changed, 0);
        Run = 1'b0;
        tick();
        check("hold release Done", Done, 1'b0);

        // Reset in the 5th SHIFT.
        load_b(8'h55);
        Din = 8'h11;
        Run = 1'b1;
        tick();
        Run = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midreset Aval", Aval, 8'h00);
        check("midreset Bval", Bval, 8'h00);
        check("midreset X",    X,    1'b0);
        check("midreset Done", Done, 1'b0);
        check("midreset Fn",   Fn,   1'b0);
        check("midreset OpA",  OpA,  8'h00);
        do_run("postreset", 8'h11, 8'h00, 1'b0, -1);
        check("postreset Aval", Aval, 8'h00);
        check("postreset Bval", Bval, 8'h00);
        tick();

        // ClearA_LoadB pulsed mid-operation is ignored: 6 * -7 = -42.
        load_b(8'h06);
        do_run("midload", 8'hF9, 8'h06, 1'b0, 5);
        check("midload Aval", Aval, 8'hFF);
        check("midload Bval", Bval, 8'hD6);
        check("midload X",    X,    1'b1);
        tick();

        // Load and Run together: load wins, stays idle.
        Din          = 8'h05;
        Run          = 1'b1;
        ClearA_LoadB = 1'b1;
        tick();
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        check("loadrun Bval", Bval, 8'h05);
        for (int i = 0; i < 20; i++) tick();
        check("loadrun idle Bval", Bval, 8'h05);
        check("loadrun idle Done", Done, 1'b0);

        // Back-to-back: 5*2 = 10, then 10*3 = 30.
        do_run("b2b1", 8'h02, 8'h05, 1'b0, -1);
        check("b2b1 Aval", Aval, 8'h00);
        check("b2b1 Bval", Bval, 8'h0A);
        tick();
        do_run("b2b2", 8'h03, 8'h0A, 1'b0, -1);
        check("b2b2 Aval", Aval, 8'h00);
        check("b2b2 Bval", Bval, 8'h1E);
        tick();

        // 1 * 127 (10-cycle latency when zero-skip is built in).
        load_b(8'h01);
        do_run("one", 8'h7F, 8'h01, 1'b0, -1);
        check("one Aval", Aval, 8'h00);
        check("one Bval", Bval, 8'h7F);
        check("one X",    X,    1'b0);
        tick();
        check("one idle Done", Done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
